spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, which sets the synchronizer depth (range 2..3) on the sclk, mosi and cs inputs.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; one clock domain only.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous to clk, active-high.
REQ-004 The block SHALL have port sclk, input, 1 bit: SPI clock from the master, asynchronous, idle low.
REQ-005 The block SHALL have port mosi, input, 1 bit: master-to-slave data, MSB first.
REQ-006 The block SHALL have port cs, input, 1 bit: chip select, active-low, asynchronous.
REQ-007 The block SHALL have port miso, output, 1 bit: slave-to-master data, MSB first.
REQ-008 The block SHALL have port tx_data, input, 8 bits: the next byte to return on miso.
REQ-009 The block SHALL have port tx_load, input, 1 bit: a load strobe, accepted only while tx_ready=1.
REQ-010 The block SHALL have port tx_ready, output, 1 bit: high when the tx holding register is empty.
REQ-011 The block SHALL have port rx_data, output, 8 bits: the last complete received byte.
REQ-012 The block SHALL have port rx_valid, output, 1 bit: a one-cycle pulse when rx_data updates.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in the SHIFT state.
REQ-014 The block SHALL have ports rx_word, output, 16 bits, and rx_word_valid, output, 1 bit, which exist only under SPI_SLAVE_WORD_EN.

Function
REQ-015 sclk, mosi and cs SHALL each pass through a SYNC_STAGES flip-flop synchronizer; edges SHALL be detected from the last synchronizer stage versus one further register.
REQ-016 The block SHALL support an sclk half-period of at least SYNC_STAGES+2 clk cycles; the master's 50-cycle half-period is nominal.
REQ-017 The state machine SHALL have states IDLE, SHIFT and DONE.
REQ-018 IDLE SHALL go to SHIFT on a detected cs falling edge; on that cycle the holding register SHALL move to the shift register (0x00 if empty), bit_cnt SHALL clear, and tx_ready SHALL return high.
REQ-019 miso SHALL present shift_tx[7] from the cycle after SHIFT entry, so the first bit is valid before the first sclk rising edge.
REQ-020 On each detected sclk falling edge in SHIFT, the synchronized mosi SHALL shift into rx_shift LSB, shift_tx SHALL shift left, and bit_cnt SHALL increment.
REQ-021 The master drives mosi while sclk is high, so the falling edge is the sample point.
REQ-022 After the 8th falling edge, SHIFT SHALL go to DONE; in DONE, rx_data SHALL load rx_shift and rx_valid SHALL pulse for exactly one cycle.
REQ-023 DONE SHALL then go to IDLE.
REQ-024 If cs rises while in SHIFT with bit_cnt<8, the block SHALL abort to IDLE, discard the partial byte, and not pulse rx_valid.
REQ-025 sclk edges SHALL be ignored while cs is high, and also in IDLE and DONE.
REQ-026 miso SHALL be 0 whenever the state is not SHIFT.
REQ-027 When tx_load=1 and tx_ready=1, the block SHALL capture tx_data and drive tx_ready low on the next cycle.
REQ-028 tx_load SHALL be ignored while tx_ready=0.
REQ-029 If tx_load and the IDLE-to-SHIFT transfer occur in the same cycle, the current byte SHALL use the old holding contents (or 0x00), and the new tx_data SHALL be held for the next byte.
REQ-030 The latency from sclk pin fall to the rx_shift update SHALL be SYNC_STAGES+1 clk cycles, and rx_valid SHALL follow the 8th update by 1 cycle.

Reset
REQ-031 On rst=1 at a clk edge, the block SHALL set state=IDLE, rx_data=0x00, rx_valid=0, tx_ready=1, busy=0 and miso=0, and clear the holding register, shift registers, bit_cnt, synchronizers (to idle levels cs=1, sclk=0) and byte index.
REQ-032 A reset during SHIFT SHALL drop the byte; if cs is low at reset exit, no transfer SHALL start until cs goes high and then falls again.

Configuration
REQ-033 With macro SPI_SLAVE_WORD_EN defined, a byte index SHALL toggle on each completed byte and rx_word/rx_word_valid SHALL be present.
REQ-034 Under SPI_SLAVE_WORD_EN, byte 0 SHALL go to rx_word[7:0] and byte 1 to rx_word[15:8]; rx_word_valid SHALL pulse with the byte-1 rx_valid.
REQ-035 Under SPI_SLAVE_WORD_EN, an aborted byte SHALL reset the byte index to 0.
REQ-036 With SPI_SLAVE_WORD_EN undefined, there SHALL be no rx_word ports and no byte index logic.

Verification
REQ-037 Load tx_data=0xA5; the master sends 0x3C -> rx_data=0x3C with a single rx_valid pulse, the master receives 0xA5, and tx_ready returns to 1.
REQ-038 No tx_load; the master sends 0xFF -> the master receives 0x00 and rx_data=0xFF.
REQ-039 cs rises after 5 sclk falling edges -> no rx_valid, rx_data unchanged; the next full byte 0x81 is received correctly.
REQ-040 With SPI_SLAVE_WORD_EN defined, the master sends 0x34 then 0x12 with a cs gap -> rx_word=0x1234, with rx_word_valid on the second byte only.
REQ-041 rst is asserted mid-byte with cs held low -> all outputs take their reset values; a subsequent full byte with cs still low is not received until cs toggles.
REQ-042 tx_load of 0x5A coincides with the IDLE-to-SHIFT transfer -> the current byte returns the previous contents; the next byte returns 0x5A.

Source files
------------

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI mode-0 style slave (sclk idle low, master drives mosi while sclk is
// high, slave samples on the sclk falling edge). All SPI pins are
// oversampled in the clk domain through a SYNC_STAGES-deep synchronizer.
//
// Parameters
//   SYNC_STAGES   synchronizer depth on sclk/mosi/cs (2..3)
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   sclk, mosi    SPI clock / data from master (asynchronous)
//   cs            chip select, active-low (asynchronous)
//   miso          data to master, MSB first, 0 outside a transfer
//   tx_data       next byte to return on miso
//   tx_load       holding-register load strobe (accepted while tx_ready)
//   tx_ready      holding register empty
//   rx_data       last complete received byte
//   rx_valid      one-cycle pulse when rx_data updates
//   busy          high while a byte is being shifted
//   rx_word       (SPI_SLAVE_WORD_EN only) byte pair, byte 0 in [7:0]
//   rx_word_valid (SPI_SLAVE_WORD_EN only) pulse with the byte-1 rx_valid
// Optional feature macro: SPI_SLAVE_WORD_EN
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
`ifdef SPI_SLAVE_WORD_EN
  ,
  output logic [15:0] rx_word,
  output logic        rx_word_valid
`endif
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned FW = 3;
  localparam int unsigned SS = SYNC_STAGES;
  // Cycles after reset until the last sync stage and its delay register
  // both hold real pin samples instead of reset values.
  localparam logic [FW-1:0] FLUSH = FW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SS-1:0]   sclk_sync_q, sclk_sync_d;
  logic [SS-1:0]   mosi_sync_q, mosi_sync_d;
  logic [SS-1:0]   cs_sync_q, cs_sync_d;
  logic            sclk_prev_q, sclk_prev_d;
  logic            cs_prev_q, cs_prev_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic            armed_q, armed_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic            tx_ready_q, tx_ready_d;
  logic [DW-1:0]   shift_tx_q, shift_tx_d;
  logic [DW-1:0]   rx_shift_q, rx_shift_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            miso_q, miso_d;
  logic            busy_q, busy_d;
`ifdef SPI_SLAVE_WORD_EN
  logic            byte_idx_q, byte_idx_d;
  logic [2*DW-1:0] rx_word_q, rx_word_d;
  logic            rx_word_valid_q, rx_word_valid_d;
`endif

  logic sclk_s_c, mosi_s_c, cs_s_c;
  logic sclk_fall_c, cs_fall_c, cs_rise_c;
  logic flushed_c, load_acc_c;

  // Synchronized pin levels and edge detection against one extra register
  always_comb begin
    sclk_s_c    = sclk_sync_q[SS-1];
    mosi_s_c    = mosi_sync_q[SS-1];
    cs_s_c      = cs_sync_q[SS-1];
    sclk_fall_c = sclk_prev_q & ~sclk_s_c;
    cs_fall_c   = cs_prev_q & ~cs_s_c;
    cs_rise_c   = ~cs_prev_q & cs_s_c;
    flushed_c   = (flush_cnt_q == FLUSH);
    load_acc_c  = tx_load & tx_ready_q;
  end

  // Next-state and datapath logic
  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SS-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SS-2:0], mosi};
    cs_sync_d   = {cs_sync_q[SS-2:0], cs};
    sclk_prev_d = sclk_s_c;
    cs_prev_d   = cs_s_c;
    flush_cnt_d = flushed_c ? flush_cnt_q : flush_cnt_q + FW'(1);
    // A cs fall only counts once cs has genuinely been seen high; this keeps
    // a cs held low across reset from starting a transfer.
    armed_d     = armed_q | (flushed_c & cs_s_c & cs_prev_q);
    hold_d      = hold_q;
    tx_ready_d  = tx_ready_q;
    shift_tx_d  = shift_tx_q;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
`ifdef SPI_SLAVE_WORD_EN
    byte_idx_d      = byte_idx_q;
    rx_word_d       = rx_word_q;
    rx_word_valid_d = 1'b0;
`endif

    if (load_acc_c) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall_c && armed_q) begin
          state_d    = ST_SHIFT;
          // Current byte uses the old holding contents; a same-cycle load
          // stays in the holding register for the next byte.
          shift_tx_d = tx_ready_q ? '0 : hold_q;
          rx_shift_d = '0;
          bit_cnt_d  = '0;
          if (!load_acc_c) tx_ready_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_c) begin
          state_d = ST_IDLE;
`ifdef SPI_SLAVE_WORD_EN
          byte_idx_d = 1'b0;
`endif
        end else if (sclk_fall_c && !cs_s_c) begin
          rx_shift_d = {rx_shift_q[DW-2:0], mosi_s_c};
          shift_tx_d = {shift_tx_q[DW-2:0], 1'b0};
          bit_cnt_d  = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(DW - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
`ifdef SPI_SLAVE_WORD_EN
        if (!byte_idx_q) begin
          rx_word_d[DW-1:0] = rx_shift_q;
        end else begin
          rx_word_d[2*DW-1:DW] = rx_shift_q;
          rx_word_valid_d      = 1'b1;
        end
        byte_idx_d = ~byte_idx_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs track the next state so they align with state_q
    miso_d = (state_d == ST_SHIFT) ? shift_tx_d[DW-1] : 1'b0;
    busy_d = (state_d == ST_SHIFT);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      flush_cnt_q <= '0;
      armed_q     <= 1'b0;
      hold_q      <= '0;
      tx_ready_q  <= 1'b1;
      shift_tx_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPI_SLAVE_WORD_EN
      byte_idx_q      <= 1'b0;
      rx_word_q       <= '0;
      rx_word_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      flush_cnt_q <= flush_cnt_d;
      armed_q     <= armed_d;
      hold_q      <= hold_d;
      tx_ready_q  <= tx_ready_d;
      shift_tx_q  <= shift_tx_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
`ifdef SPI_SLAVE_WORD_EN
      byte_idx_q      <= byte_idx_d;
      rx_word_q       <= rx_word_d;
      rx_word_valid_q <= rx_word_valid_d;
`endif
    end
  end

  assign miso     = miso_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
`ifdef SPI_SLAVE_WORD_EN
  assign rx_word       = rx_word_q;
  assign rx_word_valid = rx_word_valid_q;
`endif

endmodule
